// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, stall, flush and a bubble counter.
// Optional one-entry skid buffer (fully registered in_ready) enabled by defining PIPE_SKID_EN.
module pipe_stage_reg #(
    parameter int unsigned        CTRL_W   = 16,
    parameter int unsigned        DATA_W   = 128,
    parameter int unsigned        PC_W     = 32,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [15:0]       bubble_cnt
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic acc;
    logic rel;

    assign rel = out_valid & out_ready;
    assign acc = in_valid & in_ready;

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [PC_W-1:0]   skid_pc;

    // in_ready depends only on registered state, breaking the out_ready -> in_ready path
    assign in_ready = ~stall & ~skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_ctrl   <= CTRL_NOP;
            out_data   <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= CTRL_NOP;
            skid_data  <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_ctrl   <= CTRL_NOP;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // Skid drains first so ordering is kept; no accept is possible while it is full
            if (rel) begin
                out_valid  <= 1'b1;
                out_ctrl   <= skid_ctrl;
                out_data   <= skid_data;
                out_pc     <= skid_pc;
                skid_valid <= 1'b0;
            end
        end else if (acc) begin
            if (out_valid & ~out_ready) begin
                skid_valid <= 1'b1;
                skid_ctrl  <= in_ctrl;
                skid_data  <= in_data;
                skid_pc    <= in_pc;
            end else begin
                out_valid <= 1'b1;
                out_ctrl  <= in_ctrl;
                out_data  <= in_data;
                out_pc    <= in_pc;
            end
        end else if (rel) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_NOP;
        end
    end
`else
    assign in_ready = ~stall & (~out_valid | out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_NOP;
            out_data  <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            // Same-cycle accept is dropped; payload fields keep their last value
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_NOP;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_ctrl  <= in_ctrl;
            out_data  <= in_data;
            out_pc    <= in_pc;
        end else if (rel) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_NOP;
        end
    end
`endif

    // Saturating count of edges at which the stage was empty
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!out_valid && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver pushes expected items on accept, monitor pops on release.
// Expected in_ready values follow PIPE_SKID_EN when it is defined for the build.
module tb_pipe_stage_reg;

    localparam int unsigned CTRL_W = 16;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned PC_W   = 32;
    localparam logic [CTRL_W-1:0] NOP = 16'h0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic [PC_W-1:0]   in_pc = '0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
    logic [15:0]       bubble_cnt;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
        logic [PC_W-1:0]   p;
    } item_t;

    item_t sb_q[$];
    int    total = 0;
    int    bad   = 0;
    logic  took;
    logic  pending;

    pipe_stage_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W), .CTRL_NOP(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_pc(out_pc),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic item_t mk(input logic [PC_W-1:0] pc);
        item_t it;
        it.c = CTRL_W'(16'h8000) | CTRL_W'(pc);
        it.d = {4{pc ^ 32'hDEAD_0000}};
        it.p = pc;
        return it;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, optionally check in_ready, record accept, return at next negedge
    task automatic cyc(input logic iv, input logic [PC_W-1:0] pc, input logic st,
                       input logic fl, input logic ordy, input int exp_rdy);
        item_t it;
        it        = mk(pc);
        in_valid  = iv;
        in_pc     = pc;
        in_ctrl   = it.c;
        in_data   = it.d;
        stall     = st;
        flush     = fl;
        out_ready = ordy;
        #1;
        if (exp_rdy >= 0) chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        took = iv & in_ready;
        if (took && !fl && !rst) sb_q.push_back(it);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every release must match the oldest outstanding accepted item
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            item_t e;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL release: got pc %0h want none (t=%0t)", out_pc, $time);
            end else begin
                e = sb_q.pop_front();
                if ({out_ctrl, out_data, out_pc} !== e) begin
                    bad++;
                    $display("FAIL release: got pc %0h ctrl %0h want pc %0h ctrl %0h (t=%0t)",
                             out_pc, out_ctrl, e.p, e.c, $time);
                end
            end
        end
    end

    // Empty stage must always present the NOP control value
    always @(negedge clk) begin
        if (!rst && !out_valid) chk("nop_invariant", 128'(out_ctrl), 128'(NOP));
    end

    initial begin
        int skid_first;
        int skid_rel;
`ifdef PIPE_SKID_EN
        skid_first = 1;
        skid_rel   = 0;
`else
        skid_first = 0;
        skid_rel   = 1;
`endif
        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_ctrl", 128'(out_ctrl), 128'(NOP));
        chk("rst_pc", 128'(out_pc), 128'(0));
        chk("rst_bubble", 128'(bubble_cnt), 128'(0));
        rst = 1'b0;

        // Back-to-back stream
        cyc(1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 1);
        cyc(1'b1, 32'h04, 1'b0, 1'b0, 1'b1, 1);
        cyc(1'b1, 32'h08, 1'b0, 1'b0, 1'b1, 1);
        chk("stream_valid", 128'(out_valid), 128'(1));
        chk("stream_pc", 128'(out_pc), 128'(32'h08));
        chk("stream_bubble", 128'(bubble_cnt), 128'(1));

        // Stall one cycle: bubble inserted, then 0x10 accepted
        cyc(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 0);
        chk("stall_valid", 128'(out_valid), 128'(0));
        chk("stall_ctrl", 128'(out_ctrl), 128'(NOP));
        chk("stall_bubble", 128'(bubble_cnt), 128'(1));
        cyc(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1);
        chk("post_stall_pc", 128'(out_pc), 128'(32'h10));
        chk("post_stall_bubble", 128'(bubble_cnt), 128'(2));

        // Drain, then flush with a same-cycle accept that must be discarded
        cyc(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1);
        cyc(1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 1);
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_ctrl", 128'(out_ctrl), 128'(NOP));
        chk("flush_pc_hold", 128'(out_pc), 128'(32'h10));
        chk("flush_bubble", 128'(bubble_cnt), 128'(3));

        // Backpressure: 0x30 held, 0x34 offered
        cyc(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 1);
        chk("bp_pc", 128'(out_pc), 128'(32'h30));
        pending = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(pending, 32'h34, 1'b0, 1'b0, 1'b0, (k == 0) ? skid_first : 0);
            if (took) pending = 1'b0;
            chk("bp_hold_pc", 128'(out_pc), 128'(32'h30));
            chk("bp_hold_valid", 128'(out_valid), 128'(1));
        end
        cyc(pending, 32'h34, 1'b0, 1'b0, 1'b1, skid_rel);
        if (took) pending = 1'b0;
        chk("bp_release_pc", 128'(out_pc), 128'(32'h34));
        chk("bp_release_valid", 128'(out_valid), 128'(1));
        chk("bp_pending", 128'(pending), 128'(0));
        cyc(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1);
        chk("bp_drain_valid", 128'(out_valid), 128'(0));
        chk("bp_bubble", 128'(bubble_cnt), 128'(4));

        // Long empty run saturates the bubble counter
        repeat (66000) cyc(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, -1);
        chk("sat_bubble", 128'(bubble_cnt), 128'(16'hFFFF));
        repeat (3) cyc(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, -1);
        chk("sat_hold", 128'(bubble_cnt), 128'(16'hFFFF));

        // Reset mid-stream clears everything, then the stage works again
        cyc(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1);
        chk("pre_rst_pc", 128'(out_pc), 128'(32'h40));
        rst = 1'b1;
        cyc(1'b0, 32'h00, 1'b0, 1'b0, 1'b0, -1);
        sb_q.delete();
        chk("mid_rst_bubble", 128'(bubble_cnt), 128'(0));
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_pc", 128'(out_pc), 128'(0));
        rst = 1'b0;
        cyc(1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1);
        chk("post_rst_pc", 128'(out_pc), 128'(32'h44));
        chk("post_rst_bubble", 128'(bubble_cnt), 128'(1));
        cyc(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1);
        cyc(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1);
        chk("sb_empty", 128'(sb_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
